conv_tile_sched: RTL and testbench
==================================

CONV_TILE_SCHED -- requirements
Module: conv_tile_sched

Interface
REQ-001 Parameter WIDTH_IN, default 10, meaning input tile edge in pixels.
REQ-002 Parameter WIDTH_OUT, default WIDTH_IN-2, meaning output tile edge and tile stride.
REQ-003 Parameters TILES_X and TILES_Y, default 4 each, meaning tile grid size; the image is WIDTH_OUT*TILES_X+2 pixels wide.
REQ-004 The block SHALL use one clock, clk, and one asynchronous active-low reset, reset_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  begin frame; pulse.
REQ-008 abort  in  1  terminate frame.
REQ-009 busy  out  1  high from start acceptance to done or abort.
REQ-010 done  out  1  one-cycle pulse after the final tile write.
REQ-011 cfg_we  in  1  load configuration.
REQ-012 cfg_mask  in  9x16  kernel.
REQ-013 cfg_bias  in  16  bias.
REQ-014 rd_req  out  1  row read request.
REQ-015 rd_row  out  16  image row.
REQ-016 rd_col  out  16  first image column.
REQ-017 rd_ready  in  1  request accepted.
REQ-018 rd_valid  in  1  read data valid.
REQ-019 rd_data  in  WIDTH_IN  pixels; bit k is column rd_col+k.
REQ-020 conv_pixels_in  out  WIDTH_IN^2  tile to datapath; pixel (x,y) is at bit x+y*WIDTH_IN.
REQ-021 conv_mask  out  9x16, and conv_bias  out  16: registered configuration.
REQ-022 conv_pixels_out  in  WIDTH_OUT^2  combinational datapath result; same indexing with WIDTH_OUT.
REQ-023 wr_valid  out  1; wr_row  out  16; wr_col  out  16; wr_data  out  WIDTH_OUT: result row write.
REQ-024 wr_ready  in  1  write accepted.

Function
REQ-025 The FSM SHALL have the states IDLE, FETCH, WAIT, SETTLE, CAPTURE, WRITE, NEXT and DONE.
REQ-026 IDLE: start=1 SHALL clear the tile counters tx and ty, clear row counter r, and move to FETCH; start while not IDLE SHALL be ignored.
REQ-027 FETCH SHALL hold rd_req=1 with rd_row=ty*WIDTH_OUT+r and rd_col=tx*WIDTH_OUT stable until rd_ready=1, then move to WAIT; the block allows one outstanding read at most.
REQ-028 WAIT: rd_valid=1 SHALL write rd_data into tile bits [r*WIDTH_IN +: WIDTH_IN]; if r=WIDTH_IN-1, go to SETTLE, else increment r and return to FETCH.
REQ-029 rd_valid outside WAIT SHALL be ignored.
REQ-030 SETTLE SHALL last exactly one cycle, with conv_pixels_in stable, then go to CAPTURE.
REQ-031 CAPTURE SHALL register conv_pixels_out into the result buffer in one cycle, clear r, and go to WRITE.
REQ-032 WRITE SHALL hold wr_valid=1 with wr_row=ty*WIDTH_OUT+r, wr_col=tx*WIDTH_OUT and wr_data=result bits [r*WIDTH_OUT +: WIDTH_OUT] stable until wr_ready=1.
REQ-033 In WRITE, each accepted write SHALL increment r; acceptance at r=WIDTH_OUT-1 SHALL go to NEXT.
REQ-034 NEXT SHALL advance tx, wrapping to 0 and incrementing ty at TILES_X-1, clear r, and go to FETCH.
REQ-035 NEXT at tx=TILES_X-1 and ty=TILES_Y-1 SHALL go to DONE instead.
REQ-036 DONE SHALL assert done for one cycle and return to IDLE.
REQ-037 The tile register SHALL not change between SETTLE and the end of CAPTURE.
REQ-038 cfg_we in IDLE SHALL load conv_mask and conv_bias on the next edge; cfg_we outside IDLE SHALL be ignored.
REQ-039 cfg_we and start asserted in the same IDLE cycle SHALL load the configuration and start; the first tile uses the new values.
REQ-040 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with rd_req=wr_valid=0, no done pulse, and configuration kept.
REQ-041 Abort has priority over all other transitions; a read response arriving after abort SHALL be ignored.
REQ-042 Row and column outputs SHALL be zero-extended to 16 bits.
REQ-043 Minimum tile time SHALL be 2*WIDTH_IN+2+WIDTH_OUT+1 cycles under zero-wait handshakes.

Reset
REQ-044 Reset SHALL force IDLE, set busy, done, rd_req and wr_valid to 0, clear the tile, result, counters and address outputs to 0, and set conv_mask and conv_bias to 0.
REQ-045 Reset mid-frame SHALL behave as abort, without requiring clk.

Structure
REQ-046 The state enum and the default WIDTH_IN, WIDTH_OUT, TILES_X and TILES_Y values SHALL reside in the shared package conv_pkg.
REQ-047 The convolution datapath SHALL stay external; no sub-module is instantiated.
REQ-048 An optional sub-module conv_tile_addr SHALL compute the tile counters and addresses.

Verification
REQ-049 Scenario 1: TILES 1x1, zero-wait memory holding a checkerboard -> exactly 10 reads (rows 0..9, col 0), then 8 writes whose wr_data matches conv_pixels_out rows, and done 31 cycles after start.
REQ-050 Scenario 2: 2x2 grid -> read rd_col sequence 0,8,0,8 and rd_row bases 0,0,8,8; done pulses once.
REQ-051 Scenario 3: random rd_ready/wr_ready stalls of 0-5 cycles -> address and data stable while stalled; results identical to the zero-wait run.
REQ-052 Scenario 4: cfg_we with mask=all 0x0001 and bias=0x0003 together with start, then cfg_we mid-frame -> conv_mask and conv_bias hold the first values until IDLE.
REQ-053 Scenario 5: abort during WAIT of tile 1 -> IDLE on the next cycle, no done; a late rd_valid is ignored; a new start runs a full frame correctly.
REQ-054 Scenario 6: reset_n deasserted mid-WRITE -> all outputs zero immediately, without a clock edge.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared FSM state type and default tile geometry for the convolution tile scheduler.
package conv_pkg;

  localparam int unsigned DefWidthIn  = 10;
  localparam int unsigned DefWidthOut = DefWidthIn - 2;
  localparam int unsigned DefTilesX   = 4;
  localparam int unsigned DefTilesY   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StSettle,
    StCapture,
    StWrite,
    StNext,
    StDone
  } state_e;

endpackage

// File: rtl/conv_tile_sched.sv
// Walks a TILES_X x TILES_Y grid of overlapping tiles: fetches each input tile row by row,
// hands it to an external combinational datapath, then writes the result tile back row by row.
module conv_tile_sched
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = DefWidthIn,
  parameter int unsigned WIDTH_OUT = WIDTH_IN - (DefWidthIn - DefWidthOut),
  parameter int unsigned TILES_X   = DefTilesX,
  parameter int unsigned TILES_Y   = DefTilesY
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  input  logic                           cfg_we,
  input  logic [8:0][15:0]               cfg_mask,
  input  logic [15:0]                    cfg_bias,
  output logic                           rd_req,
  output logic [15:0]                    rd_row,
  output logic [15:0]                    rd_col,
  input  logic                           rd_ready,
  input  logic                           rd_valid,
  input  logic [WIDTH_IN-1:0]            rd_data,
  output logic [WIDTH_IN*WIDTH_IN-1:0]   conv_pixels_in,
  output logic [8:0][15:0]               conv_mask,
  output logic [15:0]                    conv_bias,
  input  logic [WIDTH_OUT*WIDTH_OUT-1:0] conv_pixels_out,
  output logic                           wr_valid,
  output logic [15:0]                    wr_row,
  output logic [15:0]                    wr_col,
  output logic [WIDTH_OUT-1:0]           wr_data,
  input  logic                           wr_ready
);

  state_e state_q, state_d;

  logic [15:0] tx_q, tx_d, ty_q, ty_d, r_q, r_d;
  logic [WIDTH_IN*WIDTH_IN-1:0]   tile_q, tile_d;
  logic [WIDTH_OUT*WIDTH_OUT-1:0] res_q, res_d;
  logic [8:0][15:0]               mask_q, mask_d;
  logic [15:0]                    bias_q, bias_d;

  logic last_rd_row, last_wr_row, last_tx, last_tile;

  assign last_rd_row = (r_q == 16'(WIDTH_IN - 1));
  assign last_wr_row = (r_q == 16'(WIDTH_OUT - 1));
  assign last_tx     = (tx_q == 16'(TILES_X - 1));
  assign last_tile   = last_tx && (ty_q == 16'(TILES_Y - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (start) state_d = StFetch;
        StFetch:   if (rd_ready) state_d = StWait;
        StWait: begin
          if (rd_valid) state_d = last_rd_row ? StSettle : StFetch;
        end
        StSettle:  state_d = StCapture;
        StCapture: state_d = StWrite;
        StWrite:   if (wr_ready && last_wr_row) state_d = StNext;
        StNext:    state_d = last_tile ? StDone : StFetch;
        StDone:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    rd_req   = (state_q == StFetch);
    wr_valid = (state_q == StWrite);
    rd_row   = '0;
    rd_col   = '0;
    wr_row   = '0;
    wr_col   = '0;
    wr_data  = '0;
    if (rd_req) begin
      rd_row = 16'(32'(ty_q) * WIDTH_OUT + 32'(r_q));
      rd_col = 16'(32'(tx_q) * WIDTH_OUT);
    end
    if (wr_valid) begin
      wr_row = 16'(32'(ty_q) * WIDTH_OUT + 32'(r_q));
      wr_col = 16'(32'(tx_q) * WIDTH_OUT);
      for (int unsigned i = 0; i < WIDTH_OUT; i++) begin
        if (r_q == 16'(i)) wr_data = res_q[i*WIDTH_OUT +: WIDTH_OUT];
      end
    end
  end

  // Tile is only written in StWait, so it is frozen through SETTLE and CAPTURE.
  always_comb begin
    tx_d   = tx_q;
    ty_d   = ty_q;
    r_d    = r_q;
    tile_d = tile_q;
    res_d  = res_q;
    mask_d = mask_q;
    bias_d = bias_q;
    if (state_q == StIdle) begin
      if (cfg_we) begin
        mask_d = cfg_mask;
        bias_d = cfg_bias;
      end
      if (start) begin
        tx_d = '0;
        ty_d = '0;
        r_d  = '0;
      end
    end else if (!abort) begin
      unique case (state_q)
        StWait: begin
          if (rd_valid) begin
            for (int unsigned i = 0; i < WIDTH_IN; i++) begin
              if (r_q == 16'(i)) tile_d[i*WIDTH_IN +: WIDTH_IN] = rd_data;
            end
            if (!last_rd_row) r_d = r_q + 16'd1;
          end
        end
        StCapture: begin
          res_d = conv_pixels_out;
          r_d   = '0;
        end
        StWrite: begin
          if (wr_ready) r_d = r_q + 16'd1;
        end
        StNext: begin
          r_d = '0;
          if (last_tx) begin
            tx_d = '0;
            ty_d = ty_q + 16'd1;
          end else begin
            tx_d = tx_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_q   <= '0;
      ty_q   <= '0;
      r_q    <= '0;
      tile_q <= '0;
      res_q  <= '0;
      mask_q <= '0;
      bias_q <= '0;
    end else begin
      tx_q   <= tx_d;
      ty_q   <= ty_d;
      r_q    <= r_d;
      tile_q <= tile_d;
      res_q  <= res_d;
      mask_q <= mask_d;
      bias_q <= bias_d;
    end
  end

  assign conv_pixels_in = tile_q;
  assign conv_mask      = mask_q;
  assign conv_bias      = bias_q;

endmodule

// File: tb/tb_conv_tile_sched.sv
// Directed bench: a 1x1 instance for exact timing, a 2x2 instance for ordering, stalls,
// configuration, abort and asynchronous reset.
module tb_conv_tile_sched;
  import conv_pkg::*;

  localparam int WI = DefWidthIn;
  localparam int WO = DefWidthOut;
  localparam int TXB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, abort, cfg_we;
  logic [8:0][15:0] cfg_mask, m1, m2;
  logic [15:0] cfg_bias;

  int n_vec = 0;
  int n_err = 0;
  int pat = 0;

  // 1x1 instance
  logic start_a, busy_a, done_a, rd_req_a, rd_ready_a, rd_valid_a, wr_valid_a, wr_ready_a;
  logic [15:0] rd_row_a, rd_col_a, wr_row_a, wr_col_a, conv_bias_a;
  logic [WI-1:0] rd_data_a;
  logic [WI*WI-1:0] pin_a;
  logic [WO*WO-1:0] pout_a;
  logic [WO-1:0] wr_data_a;
  logic [8:0][15:0] conv_mask_a;

  // 2x2 instance
  logic start_b, busy_b, done_b, rd_req_b, rd_ready_b, rd_valid_b, wr_valid_b, wr_ready_b;
  logic [15:0] rd_row_b, rd_col_b, wr_row_b, wr_col_b, conv_bias_b;
  logic [WI-1:0] rd_data_b, pend_data;
  logic [WI*WI-1:0] pin_b;
  logic [WO*WO-1:0] pout_b;
  logic [WO-1:0] wr_data_b;
  logic [8:0][15:0] conv_mask_b;

  function automatic logic img(int row, int col);
    if (pat == 0) return 1'((row + col) % 2);
    return 1'(((row * 3 + col * 5 + row * col) % 7) < 3);
  endfunction

  function automatic logic [WI-1:0] mem_row(int row, int col);
    logic [WI-1:0] d;
    for (int k = 0; k < WI; k++) d[k] = img(row, col + k);
    return d;
  endfunction

  // Stand-in datapath: out(x,y) = in(x+1,y+1) ^ in(x,y)
  function automatic logic [WO*WO-1:0] conv_model(logic [WI*WI-1:0] t);
    logic [WO*WO-1:0] o;
    for (int y = 0; y < WO; y++)
      for (int x = 0; x < WO; x++) o[x + y*WO] = t[(x + 1) + (y + 1)*WI] ^ t[x + y*WI];
    return o;
  endfunction

  function automatic logic [WO-1:0] exp_row(int row, int col);
    logic [WO-1:0] d;
    for (int k = 0; k < WO; k++) d[k] = img(row + 1, col + k + 1) ^ img(row, col + k);
    return d;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  assign pout_a = conv_model(pin_a);
  assign pout_b = conv_model(pin_b);
  assign rd_ready_a = 1'b1;
  assign wr_ready_a = 1'b1;

  conv_tile_sched #(.TILES_X(1), .TILES_Y(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort), .busy(busy_a), .done(done_a),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask), .cfg_bias(cfg_bias),
    .rd_req(rd_req_a), .rd_row(rd_row_a), .rd_col(rd_col_a), .rd_ready(rd_ready_a),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .conv_pixels_in(pin_a),
    .conv_mask(conv_mask_a), .conv_bias(conv_bias_a), .conv_pixels_out(pout_a),
    .wr_valid(wr_valid_a), .wr_row(wr_row_a), .wr_col(wr_col_a), .wr_data(wr_data_a),
    .wr_ready(wr_ready_a)
  );

  conv_tile_sched #(.TILES_X(TXB), .TILES_Y(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort), .busy(busy_b), .done(done_b),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask), .cfg_bias(cfg_bias),
    .rd_req(rd_req_b), .rd_row(rd_row_b), .rd_col(rd_col_b), .rd_ready(rd_ready_b),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .conv_pixels_in(pin_b),
    .conv_mask(conv_mask_b), .conv_bias(conv_bias_b), .conv_pixels_out(pout_b),
    .wr_valid(wr_valid_b), .wr_row(wr_row_b), .wr_col(wr_col_b), .wr_data(wr_data_b),
    .wr_ready(wr_ready_b)
  );

  // Zero-wait memory and scoreboard for the 1x1 instance
  int rda_idx = 0, wra_idx = 0;
  logic acc_a = 1'b0;
  initial forever begin
    @(negedge clk);
    rd_valid_a = acc_a;
    acc_a = rd_req_a;
    if (rd_req_a) begin
      rd_data_a = mem_row(int'(rd_row_a), int'(rd_col_a));
      check("a_rd_row", rd_row_a, rda_idx);
      check("a_rd_col", rd_col_a, 0);
      rda_idx++;
    end
    if (wr_valid_a) begin
      check("a_wr_row", wr_row_a, wra_idx);
      check("a_wr_data", wr_data_a, exp_row(wra_idx, 0));
      wra_idx++;
    end
  end

  // Memory with optional stalls / response delay and scoreboard for the 2x2 instance
  int rdb_idx = 0, wrb_idx = 0, rd_hold = 0, wr_hold = 0, dcnt = 0, rsp_delay = 0;
  bit stall = 0, sb_on = 0, pend = 0, rd_stall = 0, wr_stall = 0;
  logic [32:0] rd_last;
  logic [32+WO:0] wr_last;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      rd_valid_b = 0; rd_ready_b = 0; wr_ready_b = 0;
      pend = 0; rd_hold = 0; wr_hold = 0; rd_stall = 0; wr_stall = 0;
    end else begin
      if (rd_stall) check("b_rd_stable", {rd_req_b, rd_row_b, rd_col_b}, rd_last);
      if (wr_stall) check("b_wr_stable", {wr_valid_b, wr_row_b, wr_col_b, wr_data_b}, wr_last);
      rd_valid_b = 1'b0;
      if (pend) begin
        if (dcnt == 0) begin
          rd_valid_b = 1'b1;
          rd_data_b = pend_data;
          pend = 0;
        end else dcnt--;
      end
      rd_ready_b = 1'b0;
      if (rd_req_b) begin
        if (rd_hold == 0) rd_ready_b = 1'b1; else rd_hold--;
      end
      wr_ready_b = 1'b0;
      if (wr_valid_b) begin
        if (wr_hold == 0) wr_ready_b = 1'b1; else wr_hold--;
      end
      if (rd_req_b && rd_ready_b) begin
        pend = 1; dcnt = rsp_delay;
        pend_data = mem_row(int'(rd_row_b), int'(rd_col_b));
        rd_hold = stall ? int'($urandom_range(0, 5)) : 0;
        if (sb_on) begin
          check("b_rd_row", rd_row_b, ((rdb_idx / WI) / TXB) * WO + rdb_idx % WI);
          check("b_rd_col", rd_col_b, ((rdb_idx / WI) % TXB) * WO);
        end
        rdb_idx++;
      end
      if (wr_valid_b && wr_ready_b) begin
        wr_hold = stall ? int'($urandom_range(0, 5)) : 0;
        if (sb_on) begin
          check("b_wr_row", wr_row_b, ((wrb_idx / WO) / TXB) * WO + wrb_idx % WO);
          check("b_wr_col", wr_col_b, ((wrb_idx / WO) % TXB) * WO);
          check("b_wr_data", wr_data_b,
                exp_row(((wrb_idx / WO) / TXB) * WO + wrb_idx % WO, ((wrb_idx / WO) % TXB) * WO));
        end
        wrb_idx++;
      end
      rd_stall = rd_req_b && !rd_ready_b;
      rd_last  = {rd_req_b, rd_row_b, rd_col_b};
      wr_stall = wr_valid_b && !wr_ready_b;
      wr_last  = {wr_valid_b, wr_row_b, wr_col_b, wr_data_b};
    end
  end

  int done_cnt = 0;
  initial forever begin
    @(posedge done_b);
    done_cnt++;
  end

  task automatic run_frame_b(input int budget, input bit with_cfg, input bit mid_cfg,
                             output int cycles);
    rdb_idx = 0;
    wrb_idx = 0;
    start_b = 1'b1;
    cfg_we  = with_cfg;
    cycles  = 0;
    do begin
      @(negedge clk);
      cycles++;
      start_b = 1'b0;
      if (cycles == 1) cfg_we = 1'b0;
      if (with_cfg && cycles == 2) begin
        check("s4_mask_loaded", conv_mask_b, m1);
        check("s4_bias_loaded", conv_bias_b, 16'h0003);
      end
      if (mid_cfg && cycles == 40) begin
        cfg_mask = m2; cfg_bias = 16'h00aa; cfg_we = 1'b1;
      end
      if (mid_cfg && cycles == 42) begin
        cfg_we = 1'b0;
        check("s4_mask_held", conv_mask_b, m1);
        check("s4_bias_held", conv_bias_b, 16'h0003);
      end
    end while (!done_b && cycles < budget);
    check("b_done_seen", done_b, 1'b1);
    check("b_rd_count", rdb_idx, 4 * WI);
    check("b_wr_count", wrb_idx, 4 * WO);
    @(negedge clk);
    check("b_done_pulse", done_b, 1'b0);
    check("b_busy_end", busy_b, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    reset_n = 0; start_a = 0; start_b = 0; abort = 0; cfg_we = 0;
    cfg_mask = '0; cfg_bias = '0;
    m1 = {9{16'h0001}};
    m2 = {9{16'hffff}};
    #12;
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_done_b", done_b, 1'b0);
    check("rst_rd_req_b", rd_req_b, 1'b0);
    check("rst_wr_valid_b", wr_valid_b, 1'b0);
    check("rst_rd_row_b", rd_row_b, 0);
    check("rst_mask_b", conv_mask_b, 0);
    check("rst_tile_b", pin_b, 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    // Scenario 1: 1x1 checkerboard, exact latency
    pat = 0;
    start_a = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start_a = 0;
    end while (!done_a && n < 200);
    check("s1_done_latency", n - 1, 31);
    check("s1_reads", rda_idx, WI);
    check("s1_writes", wra_idx, WO);
    @(negedge clk);
    check("s1_done_pulse", done_a, 1'b0);
    check("s1_busy_end", busy_a, 1'b0);

    // Scenario 2: 2x2 grid, zero wait
    pat = 1; sb_on = 1; stall = 0; rsp_delay = 0;
    d0 = done_cnt;
    run_frame_b(600, 0, 0, n);
    check("s2_frame_latency", n - 1, 4 * 31);
    check("s2_one_done", done_cnt - d0, 1);

    // Scenario 3: random handshake stalls
    stall = 1;
    d0 = done_cnt;
    run_frame_b(4000, 0, 0, n);
    check("s3_one_done", done_cnt - d0, 1);
    stall = 0;

    // Scenario 4: config with start, ignored mid-frame
    cfg_mask = m1; cfg_bias = 16'h0003;
    run_frame_b(600, 1, 1, n);
    check("s4_mask_after", conv_mask_b, m1);
    check("s4_bias_after", conv_bias_b, 16'h0003);
    cfg_mask = m2; cfg_bias = 16'h00aa; cfg_we = 1;
    @(negedge clk);
    cfg_we = 0;
    check("s4_mask_idle_load", conv_mask_b, m2);
    check("s4_bias_idle_load", conv_bias_b, 16'h00aa);

    // Scenario 5: abort while waiting on tile 1's first read
    rsp_delay = 3;
    d0 = done_cnt;
    rdb_idx = 0; wrb_idx = 0;
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    n = 0;
    while (!(rd_req_b && rd_col_b == 16'd8) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("s5_reached_tile1", rd_col_b, 16'd8);
    @(negedge clk);
    check("s5_in_wait", {busy_b, rd_req_b}, 2'b10);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("s5_idle_busy", busy_b, 1'b0);
    check("s5_idle_rd_req", rd_req_b, 1'b0);
    check("s5_idle_wr_valid", wr_valid_b, 1'b0);
    repeat (6) @(negedge clk);
    check("s5_late_rsp_busy", busy_b, 1'b0);
    check("s5_no_done", done_cnt - d0, 0);
    check("s5_cfg_kept", conv_mask_b, m2);
    rsp_delay = 0;
    run_frame_b(600, 0, 0, n);
    check("s5_restart_one_done", done_cnt - d0, 1);

    // Scenario 6: asynchronous reset mid-WRITE
    d0 = done_cnt;
    rdb_idx = 0; wrb_idx = 0;
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    n = 0;
    while (!(wr_valid_b && wrb_idx >= 3) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("s6_in_write", wr_valid_b, 1'b1);
    #1 reset_n = 0;
    #1;
    check("s6_busy", busy_b, 1'b0);
    check("s6_done", done_b, 1'b0);
    check("s6_rd_req", rd_req_b, 1'b0);
    check("s6_wr_valid", wr_valid_b, 1'b0);
    check("s6_wr_addr", {wr_row_b, wr_col_b}, 0);
    check("s6_wr_data", wr_data_b, 0);
    check("s6_rd_addr", {rd_row_b, rd_col_b}, 0);
    check("s6_tile", pin_b, 0);
    check("s6_cfg", {conv_mask_b, conv_bias_b}, 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    check("s6_idle_after", busy_b, 1'b0);
    check("s6_no_done", done_cnt - d0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
